// File: rtl/mem_port_arbiter.sv
// Arbitrates the single cache port between instruction fetch (I) and the
// load/store queue (D); D has priority, a starvation counter forces I through.
module mem_port_arbiter #(
    parameter int width        = 32,
    parameter int starve_limit = 4,
    parameter int cnt_w        = 3
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             i_read,
    input  logic [width-1:0] i_address,
    output logic [width-1:0] i_rdata,
    output logic             i_resp,

    input  logic             d_read,
    input  logic             d_write,
    input  logic [3:0]       d_byte_enable,
    input  logic [width-1:0] d_address,
    input  logic [width-1:0] d_wdata,
    output logic [width-1:0] d_rdata,
    output logic             d_resp,

    output logic             mem_read,
    output logic             mem_write,
    output logic [3:0]       mem_byte_enable,
    output logic [width-1:0] mem_address,
    output logic [width-1:0] mem_wdata,
    input  logic [width-1:0] mem_rdata,
    input  logic             mem_resp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t           state;
    logic [cnt_w-1:0] starve_cnt;

    logic dreq;
    logic i_starved;
    logic grant_d;
    logic grant_i;

    assign dreq      = d_read | d_write;
    assign i_starved = i_read && (starve_cnt == cnt_w'(starve_limit));
    assign grant_d   = (state == IDLE) && dreq && !i_starved;
    assign grant_i   = (state == IDLE) && !grant_d && i_read;

    // Responses are a pure qualification of mem_resp by the owner, so a
    // requester sees its data in the very cycle the cache answers.
    assign i_resp  = mem_resp && (state == INST);
    assign d_resp  = mem_resp && (state == DATA);
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // NOTE: state and registered outputs use non-blocking assignments so every
    // branch below sees the values from before this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            starve_cnt      <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= 4'b0000;
            mem_address     <= '0;
            mem_wdata       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state           <= DATA;
                        mem_address     <= d_address;
                        mem_wdata       <= d_wdata;
                        mem_byte_enable <= d_write ? d_byte_enable : 4'b1111;
                        mem_write       <= d_write;
                        mem_read        <= d_read & ~d_write;
                        if (!i_read) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != cnt_w'(starve_limit)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else if (grant_i) begin
                        state           <= INST;
                        mem_address     <= i_address;
                        mem_byte_enable <= 4'b1111;
                        mem_write       <= 1'b0;
                        mem_read        <= 1'b1;
                        starve_cnt      <= '0;
                    end
                end

                INST, DATA: begin
                    // Address and write data are left in place after completion.
                    if (mem_resp) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int W     = 32;
    localparam int LIMIT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read;
    logic [W-1:0] i_address;
    logic [W-1:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [3:0]   d_byte_enable;
    logic [W-1:0] d_address;
    logic [W-1:0] d_wdata;
    logic [W-1:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable;
    logic [W-1:0] mem_address;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;
    logic         mem_resp;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.width(W), .starve_limit(LIMIT), .cnt_w(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_read         (i_read),
        .i_address      (i_address),
        .i_rdata        (i_rdata),
        .i_resp         (i_resp),
        .d_read         (d_read),
        .d_write        (d_write),
        .d_byte_enable  (d_byte_enable),
        .d_address      (d_address),
        .d_wdata        (d_wdata),
        .d_rdata        (d_rdata),
        .d_resp         (d_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_byte_enable(mem_byte_enable),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        i_read = 0; i_address = '0;
        d_read = 0; d_write = 0; d_byte_enable = '0; d_address = '0; d_wdata = '0;
        mem_rdata = '0; mem_resp = 0;
    endtask

    // Leaves the bench just after a falling edge with reset released.
    task automatic do_reset();
        rst = 0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    // One row = one clock cycle: inputs driven after the falling edge, every
    // output compared shortly after, before the next rising edge.
    typedef struct {
        logic         ir;
        logic [W-1:0] ia;
        logic         dr;
        logic         dw;
        logic [3:0]   be;
        logic [W-1:0] da;
        logic [W-1:0] dwd;
        logic         mr;
        logic [W-1:0] mrd;
        logic         e_rd;
        logic         e_wr;
        logic [3:0]   e_be;
        logic [W-1:0] e_addr;
        logic [W-1:0] e_wd;
        logic         e_ir;
        logic         e_dr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic ir, logic [W-1:0] ia, logic dr, logic dw, logic [3:0] be,
        logic [W-1:0] da, logic [W-1:0] dwd, logic mr, logic [W-1:0] mrd,
        logic e_rd, logic e_wr, logic [3:0] e_be, logic [W-1:0] e_addr,
        logic [W-1:0] e_wd, logic e_ir, logic e_dr);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.be = be; v.da = da; v.dwd = dwd;
        v.mr = mr; v.mrd = mrd; v.e_rd = e_rd; v.e_wr = e_wr; v.e_be = e_be;
        v.e_addr = e_addr; v.e_wd = e_wd; v.e_ir = e_ir; v.e_dr = e_dr;
        return v;
    endfunction

    // Reference model: one outstanding transaction record plus a count of
    // consecutive D wins while fetch was waiting.
    typedef enum {OWN_NONE, OWN_I, OWN_D} owner_t;
    owner_t       m_owner;
    int           m_starve;
    logic         m_rd, m_wr;
    logic [3:0]   m_be;
    logic [W-1:0] m_addr, m_wd;

    task automatic model_reset();
        m_owner = OWN_NONE; m_starve = 0;
        m_rd = 0; m_wr = 0; m_be = '0; m_addr = '0; m_wd = '0;
    endtask

    task automatic model_edge();
        if (m_owner == OWN_NONE) begin
            if ((d_read || d_write) && !(i_read && m_starve == LIMIT)) begin
                m_owner  = OWN_D;
                m_addr   = d_address;
                m_wd     = d_wdata;
                m_wr     = d_write;
                m_rd     = !d_write;
                m_be     = d_write ? d_byte_enable : 4'hF;
                m_starve = i_read ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
            end else if (i_read) begin
                m_owner  = OWN_I;
                m_addr   = i_address;
                m_rd     = 1; m_wr = 0; m_be = 4'hF;
                m_starve = 0;
            end
        end else if (mem_resp) begin
            m_owner = OWN_NONE;
            m_rd = 0; m_wr = 0;
        end
    endtask

    typedef enum {G_I, G_D} grant_t;
    grant_t grants[10];
    grant_t exp_grants[10];
    int     pre_i_cnt[10];

    initial begin
        int dresp_count;
        int ngrants;
        int age;
        int last_cnt;

        do_reset();

        // ---- table: lone fetch, store, read+write collision, idle resp, load ----
        vecs.push_back(mk(1, 32'h100, 0, 0, 4'h0, 32'h0,    32'h0,  0, 32'h0,        0, 0, 4'h0, 32'h0,    32'h0,  0, 0));
        vecs.push_back(mk(1, 32'h100, 0, 0, 4'h0, 32'h0,    32'h0,  0, 32'h0,        1, 0, 4'hF, 32'h100,  32'h0,  0, 0));
        vecs.push_back(mk(1, 32'h100, 0, 0, 4'h0, 32'h0,    32'h0,  0, 32'h0,        1, 0, 4'hF, 32'h100,  32'h0,  0, 0));
        vecs.push_back(mk(1, 32'h100, 0, 0, 4'h0, 32'h0,    32'h0,  1, 32'hDEADBEEF, 1, 0, 4'hF, 32'h100,  32'h0,  1, 0));
        vecs.push_back(mk(0, 32'h100, 0, 0, 4'h0, 32'h0,    32'h0,  0, 32'h0,        0, 0, 4'hF, 32'h100,  32'h0,  0, 0));
        vecs.push_back(mk(0, 32'h0,   0, 1, 4'h1, 32'h2004, 32'hA5, 0, 32'h0,        0, 0, 4'hF, 32'h100,  32'h0,  0, 0));
        vecs.push_back(mk(0, 32'h0,   0, 1, 4'h1, 32'h2004, 32'hA5, 0, 32'h0,        0, 1, 4'h1, 32'h2004, 32'hA5, 0, 0));
        vecs.push_back(mk(0, 32'h0,   0, 1, 4'h1, 32'h2004, 32'hA5, 1, 32'h12345678, 0, 1, 4'h1, 32'h2004, 32'hA5, 0, 1));
        vecs.push_back(mk(0, 32'h0,   0, 0, 4'h0, 32'h0,    32'h0,  0, 32'h0,        0, 0, 4'h1, 32'h2004, 32'hA5, 0, 0));
        vecs.push_back(mk(0, 32'h0,   1, 1, 4'h6, 32'h3000, 32'h55, 0, 32'h0,        0, 0, 4'h1, 32'h2004, 32'hA5, 0, 0));
        vecs.push_back(mk(0, 32'h0,   1, 1, 4'h6, 32'h3000, 32'h55, 0, 32'h0,        0, 1, 4'h6, 32'h3000, 32'h55, 0, 0));
        vecs.push_back(mk(0, 32'h0,   1, 1, 4'h6, 32'h3000, 32'h55, 1, 32'hCAFEF00D, 0, 1, 4'h6, 32'h3000, 32'h55, 0, 1));
        vecs.push_back(mk(0, 32'h0,   0, 0, 4'h0, 32'h0,    32'h0,  1, 32'h11111111, 0, 0, 4'h6, 32'h3000, 32'h55, 0, 0));
        vecs.push_back(mk(0, 32'h0,   1, 0, 4'h3, 32'h44,   32'h77, 0, 32'h0,        0, 0, 4'h6, 32'h3000, 32'h55, 0, 0));
        vecs.push_back(mk(0, 32'h0,   1, 0, 4'h3, 32'h44,   32'h77, 0, 32'h0,        1, 0, 4'hF, 32'h44,   32'h77, 0, 0));
        vecs.push_back(mk(0, 32'h0,   1, 1, 4'h0, 32'h88,   32'h99, 1, 32'h0BADC0DE, 1, 0, 4'hF, 32'h44,   32'h77, 0, 1));
        vecs.push_back(mk(0, 32'h0,   0, 0, 4'h0, 32'h0,    32'h0,  0, 32'h0,        0, 0, 4'hF, 32'h44,   32'h77, 0, 0));

        foreach (vecs[k]) begin
            i_read = vecs[k].ir; i_address = vecs[k].ia;
            d_read = vecs[k].dr; d_write = vecs[k].dw; d_byte_enable = vecs[k].be;
            d_address = vecs[k].da; d_wdata = vecs[k].dwd;
            mem_resp = vecs[k].mr; mem_rdata = vecs[k].mrd;
            #1;
            check($sformatf("vec%0d mem_read", k),    W'(mem_read),        W'(vecs[k].e_rd));
            check($sformatf("vec%0d mem_write", k),   W'(mem_write),       W'(vecs[k].e_wr));
            check($sformatf("vec%0d mem_be", k),      W'(mem_byte_enable), W'(vecs[k].e_be));
            check($sformatf("vec%0d mem_address", k), mem_address,         vecs[k].e_addr);
            check($sformatf("vec%0d mem_wdata", k),   mem_wdata,           vecs[k].e_wd);
            check($sformatf("vec%0d i_resp", k),      W'(i_resp),          W'(vecs[k].e_ir));
            check($sformatf("vec%0d d_resp", k),      W'(d_resp),          W'(vecs[k].e_dr));
            if (vecs[k].e_ir) check($sformatf("vec%0d i_rdata", k), i_rdata, vecs[k].mrd);
            if (vecs[k].e_dr) check($sformatf("vec%0d d_rdata", k), d_rdata, vecs[k].mrd);
            @(negedge clk);
        end

        // ---- asynchronous reset in the middle of a store ----
        do_reset();
        d_write = 1; d_byte_enable = 4'h3; d_address = 32'h40; d_wdata = 32'h1234;
        @(negedge clk);
        #1 check("rst pre mem_write", W'(mem_write), 1);
        #1 rst = 0;
        mem_resp = 1;
        #1;
        check("rst mem_write", W'(mem_write), 0);
        check("rst mem_address", mem_address, 0);
        check("rst mem_be", W'(mem_byte_enable), 0);
        check("rst no d_resp", W'(d_resp), 0);
        @(negedge clk);
        rst = 1; d_write = 0; mem_resp = 1;
        #1;
        check("rst post d_resp", W'(d_resp), 0);
        check("rst post mem_write", W'(mem_write), 0);
        @(negedge clk);
        mem_resp = 0;
        #1 check("rst post idle mem_read", W'(mem_read), 0);

        // ---- starvation: both sides request continuously ----
        do_reset();
        i_read = 1; i_address = 32'h1000;
        d_read = 1; d_address = 32'h2000;
        ngrants = 0; age = 0; last_cnt = 0;
        for (int cyc = 0; cyc < 200 && ngrants < 10; cyc++) begin
            mem_resp = 0;
            #1;
            if (mem_read) begin
                age++;
                if (age == 1) begin
                    grants[ngrants]    = (mem_address == 32'h1000) ? G_I : G_D;
                    pre_i_cnt[ngrants] = last_cnt;
                    ngrants++;
                end
                if (age == 2) mem_resp = 1;
            end else begin
                age = 0;
                last_cnt = int'(dut.starve_cnt);
            end
            @(negedge clk);
        end
        check("starve grant count", ngrants, 10);
        for (int g = 0; g < 10; g++) exp_grants[g] = (g == 4 || g == 9) ? G_I : G_D;
        for (int g = 0; g < ngrants; g++) begin
            check($sformatf("starve grant%0d", g), W'(grants[g]), W'(exp_grants[g]));
            if (exp_grants[g] == G_I)
                check($sformatf("starve cnt before grant%0d", g), pre_i_cnt[g], LIMIT);
        end

        // ---- response on the first strobe cycle, then a stray idle resp ----
        do_reset();
        d_read = 1; d_address = 32'h500;
        dresp_count = 0;
        #1 dresp_count += int'(d_resp);
        @(negedge clk);
        mem_resp = 1; mem_rdata = 32'hABCD0001;
        #1;
        check("bubble strobe", W'(mem_read), 1);
        dresp_count += int'(d_resp);
        @(negedge clk);
        #1;
        check("bubble idle mem_read", W'(mem_read), 0);
        check("bubble idle i_resp", W'(i_resp), 0);
        dresp_count += int'(d_resp);
        check("bubble single d_resp", dresp_count, 1);
        @(negedge clk);
        mem_resp = 0; d_read = 0;
        #1 check("bubble regrant", W'(mem_read), 1);

        // ---- request dropped while granted ----
        do_reset();
        d_read = 1; d_address = 32'h600;
        @(negedge clk);
        d_read = 0;
        #1 check("drop strobe", W'(mem_read), 1);
        @(negedge clk);
        #1;
        check("drop held mem_read", W'(mem_read), 1);
        check("drop held address", mem_address, 32'h600);
        check("drop no early resp", W'(d_resp), 0);
        @(negedge clk);
        mem_resp = 1; mem_rdata = 32'h600D600D;
        #1;
        check("drop d_resp", W'(d_resp), 1);
        check("drop d_rdata", d_rdata, 32'h600D600D);
        @(negedge clk);
        mem_resp = 0;
        #1;
        check("drop idle mem_read", W'(mem_read), 0);
        check("drop idle d_resp", W'(d_resp), 0);

        // ---- randomized traffic against the reference model ----
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            i_read        = ($urandom_range(0, 2) != 0);
            i_address     = $urandom & 32'hFFFF_FFFC;
            d_read        = ($urandom_range(0, 1) != 0);
            d_write       = ($urandom_range(0, 2) == 0);
            d_byte_enable = 4'($urandom);
            d_address     = $urandom & 32'hFFFF_FFFC;
            d_wdata       = $urandom;
            mem_rdata     = $urandom;
            mem_resp      = ($urandom_range(0, 2) == 0);
            #1;
            check("rnd mem_read",    W'(mem_read),        W'(m_rd));
            check("rnd mem_write",   W'(mem_write),       W'(m_wr));
            check("rnd mem_be",      W'(mem_byte_enable), W'(m_be));
            check("rnd mem_address", mem_address,         m_addr);
            check("rnd mem_wdata",   mem_wdata,           m_wd);
            check("rnd i_resp",      W'(i_resp),          W'(mem_resp && m_owner == OWN_I));
            check("rnd d_resp",      W'(d_resp),          W'(mem_resp && m_owner == OWN_D));
            if (m_owner == OWN_D) check("rnd d_rdata", d_rdata, mem_rdata);
            if (m_owner == OWN_I) check("rnd i_rdata", i_rdata, mem_rdata);
            model_edge();
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
